pipe_issue_ctrl: RTL
====================

// Module: pipe_issue_ctrl
// PURPOSE
//  Front end for the 4-stage register/ALU/store pipeline.
//  - Accepts instructions (rs1, rs2, rd, func, addr) over a valid/ready handshake.
//  - Buffers them in a small FIFO and issues at most one per cycle on the pipeline input bus.
//  - Inserts bubbles on RAW hazards against rd of recently issued instructions, so the
//    pipeline never reads a regbank entry before the earlier writeback lands.
// PARAMETERS
//  FIFO_DEPTH  4  instruction queue entries, power of two, >=2
//  HAZ_WIN     3  issued-instruction window checked for RAW hazards (pipeline writeback distance)
//  REG_AW      4  register index width (16-entry regbank)
//  FUNC_W      4  ALU function code width
//  ADDR_W      8  store address width
// PORTS
//  clk          in   1        single system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  flush        in   1        sync clear of queue and hazard window
//  in_valid     in   1        upstream instruction valid
//  in_ready     out  1        queue can accept this cycle
//  in_rs1       in   REG_AW   source register 1
//  in_rs2       in   REG_AW   source register 2
//  in_rd        in   REG_AW   destination register
//  in_func      in   FUNC_W   ALU function code
//  in_addr      in   ADDR_W   store address for the result
//  iss_valid    out  1        issue bus carries a real instruction (0 = bubble)
//  iss_rs1/rs2/rd  out  REG_AW   issued register fields
//  iss_func     out  FUNC_W   issued function
//  iss_addr     out  ADDR_W   issued address
//  stall_cnt    out  16       saturating count of hazard bubbles since reset/flush
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty; window cleared; in_ready=1; iss_* = 0; stall_cnt = 0.
//  - Accept: in_valid & in_ready at an edge pushes one entry.
//    - in_ready = (count < FIFO_DEPTH); registered-state only, no combinational path from issue.
//  - Full: in_ready = 0, even on a cycle where a pop occurs.
//  - Window: shift register win[0..HAZ_WIN-1] of {valid, rd}; win[0] mirrors the current issue bus.
//    - Shifts every cycle; bubbles enter as valid = 0.
//  - Hazard: head.rs1 or head.rs2 equals rd of any valid window entry.
//  - Each edge:
//    - FIFO non-empty and no hazard: pop head; drive iss_* <= head, iss_valid <= 1.
//    - Hazard: iss_valid <= 0; iss fields <= 0; stall_cnt++ (saturate at 0xFFFF).
//    - Empty: iss_valid <= 0; fields <= 0; no stall count.
//  - Latency: push into empty queue at edge N -> iss_valid = 1 after edge N+1.
//  - Dependent back-to-back pair -> exactly HAZ_WIN bubbles.
//  - Simultaneous push and pop at non-full: count unchanged; both take effect.
//  - Pointers wrap modulo FIFO_DEPTH; count is a separate log2(FIFO_DEPTH)+1-bit field.
//  - flush: next edge empties FIFO, clears window and stall_cnt, iss_* <= 0.
//    - A concurrent push is dropped; flush has priority.
//  - Reset mid-operation: immediate return to reset values; no partial issue.
//  - No func decoding beyond passthrough; all rd values, including 0, are hazard-tracked.
// STRUCTURE
//  - Package pipe_pkg:
//    - REG_AW/FUNC_W/ADDR_W defaults
//    - func codes: ADD=0, SUB=1, MUL=2, SLA=11
//    - struct instr_t {rs1, rs2, rd, func, addr}
//  - Sub-module: pipe_instr_fifo (sync FIFO of instr_t with count, push/pop/flush).
//  - Hazard window and issue register stay in the top.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> iss_valid=0, in_ready=1, stall_cnt=0 immediately;
//     queue empty after release.
//  2. Independent stream: ADD(1,5,rd10), MUL(3,8,rd12), SLA(7,3,rd13) pushed on
//     consecutive cycles -> issued on 3 consecutive cycles, stall_cnt=0.
//  3. Direct RAW: ADD(1,5,rd10) then SUB(10,5,rd14) -> 3 bubbles, SUB issues 4 cycles
//     after ADD, stall_cnt=3.
//  4. Distance-2 RAW: ADD(rd10), MUL(rd12), SUB(rs1=10) -> 2 bubbles before SUB, stall_cnt=2.
//  5. Full/wrap: hold a hazard while pushing 5 -> in_ready=0 after 4 accepted.
//     Release, push 8 more -> all 12 issue in order, addrs 125..136 intact across pointer wrap.
//  6. Flush with 3 queued and push asserted -> next cycle iss_valid=0, in_ready=1;
//     nothing further issues; stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline issue front end.
package pipe_pkg;

    localparam int REG_AW         = 4;
    localparam int FUNC_W         = 4;
    localparam int ADDR_W         = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_HAZ_WIN    = 3;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_ADD = 4'd0,
        FUNC_SUB = 4'd1,
        FUNC_MUL = 4'd2,
        FUNC_SLA = 4'd11
    } func_e;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    // True when a valid in-flight destination matches either source of ins.
    function automatic logic src_hit(input instr_t ins, input logic wvalid,
                                     input logic [REG_AW-1:0] wrd);
        return wvalid & ((ins.rs1 == wrd) | (ins.rs2 == wrd));
    endfunction

endpackage

// File: rtl/pipe_instr_fifo.sv
// Small synchronous instruction queue with an explicit occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module pipe_instr_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  instr_t        wdata,
    input  logic          pop,
    output instr_t        rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    instr_t          mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign push_ok_s = push & (count_r != CW'(DEPTH));
    assign pop_ok_s  = pop  & (count_r != {CW{1'b0}});
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = (count_r == {CW{1'b0}});

    // Storage, pointer and occupancy update; flush empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue front end: queues instructions and issues one per cycle, inserting
// bubbles while the head reads a register still being produced in the pipe.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int HAZ_WIN    = DEF_HAZ_WIN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              iss_valid,
    output logic [REG_AW-1:0] iss_rs1,
    output logic [REG_AW-1:0] iss_rs2,
    output logic [REG_AW-1:0] iss_rd,
    output logic [FUNC_W-1:0] iss_func,
    output logic [ADDR_W-1:0] iss_addr,
    output logic [15:0]       stall_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    instr_t            in_instr_s;
    instr_t            head_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              hazard_s;
    logic              issue_s;
    logic              stall_s;

    instr_t            iss_r;
    logic              iss_valid_r;
    logic [15:0]       stall_cnt_r;
    logic              win_valid_r [HAZ_WIN];
    logic [REG_AW-1:0] win_rd_r    [HAZ_WIN];

    assign in_instr_s = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};

    // Ready depends only on stored occupancy, so a full queue refuses even while popping.
    assign in_ready = (fifo_count_s < CW'(FIFO_DEPTH));
    assign push_s   = in_valid & in_ready & ~flush;
    assign issue_s  = ~fifo_empty_s & ~hazard_s;
    assign stall_s  = ~fifo_empty_s & hazard_s;
    assign pop_s    = issue_s & ~flush;

    pipe_instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_s),
        .wdata (in_instr_s),
        .pop   (pop_s),
        .rdata (head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    // RAW check of the queue head against every in-flight destination.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (src_hit(head_s, win_valid_r[i], win_rd_r[i])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Issue register, hazard window shift and saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_r       <= '0;
            iss_valid_r <= 1'b0;
            stall_cnt_r <= 16'd0;
            for (int i = 0; i < HAZ_WIN; i++) begin
                win_valid_r[i] <= 1'b0;
                win_rd_r[i]    <= {REG_AW{1'b0}};
            end
        end else if (flush) begin
            iss_r       <= '0;
            iss_valid_r <= 1'b0;
            stall_cnt_r <= 16'd0;
            for (int i = 0; i < HAZ_WIN; i++) begin
                win_valid_r[i] <= 1'b0;
                win_rd_r[i]    <= {REG_AW{1'b0}};
            end
        end else begin
            iss_r          <= issue_s ? head_s : '0;
            iss_valid_r    <= issue_s;
            win_valid_r[0] <= issue_s;
            win_rd_r[0]    <= issue_s ? head_s.rd : {REG_AW{1'b0}};
            for (int i = 1; i < HAZ_WIN; i++) begin
                win_valid_r[i] <= win_valid_r[i-1];
                win_rd_r[i]    <= win_rd_r[i-1];
            end
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign iss_valid = iss_valid_r;
    assign iss_rs1   = iss_r.rs1;
    assign iss_rs2   = iss_r.rs2;
    assign iss_rd    = iss_r.rd;
    assign iss_func  = iss_r.func;
    assign iss_addr  = iss_r.addr;
    assign stall_cnt = stall_cnt_r;

endmodule
